// File: rtl/demux_capture_bank_pkg.sv
// Shared constants for the demux capture bank: default channel count, data width,
// and the channel-index width derivation.
package demux_capture_bank_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 8;

  // Channel index width; a single-bit index is kept even for degenerate counts.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker. It selects the first requesting slot at or after
// the pointer, searching modulo N. When locked, it re-presents the pointer slot.
module rr_arbiter
  import demux_capture_bank_pkg::*;
#(
  parameter  int N    = N_DEF,
  localparam int LOGN = idx_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [LOGN-1:0] ptr,
  input  logic            lock,
  output logic [LOGN-1:0] grant,
  output logic            grantValid
);

  int unsigned idx;

  // First full slot at or after ptr; while locked the grant is pinned to ptr.
  always_comb begin
    grant      = '0;
    grantValid = 1'b0;
    idx        = 0;
    if (lock) begin
      grant      = ptr;
      grantValid = req[ptr];
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        idx = (32'(ptr) + k) % N;
        if (!grantValid && req[LOGN'(idx)]) begin
          grantValid = 1'b1;
          grant      = LOGN'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/demux_capture_bank.sv
// Per-channel capture slots fed by demux strobes. Full slots are drained round-robin
// over a valid/ready handshake. The bank keeps sticky overflow and multi-hot flags.
module demux_capture_bank
  import demux_capture_bank_pkg::*;
#(
  parameter  int N    = N_DEF,
  parameter  int W    = W_DEF,
  localparam int LOGN = idx_width(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    inStrobe,
  input  logic [W-1:0]    inData,
  output logic            outValid,
  input  logic            outReady,
  output logic [W-1:0]    outData,
  output logic [LOGN-1:0] outChannel,
  output logic [N-1:0]    slotFull,
  output logic [N-1:0]    overflow,
  output logic            multiHot,
  input  logic            clearFlags
);

  logic [W-1:0]    slot_data [N];
  logic [LOGN-1:0] ptr;
  logic            lock;
  logic [LOGN-1:0] grant;
  logic            grant_valid;
  logic            fire;
  logic            multi_now;

  rr_arbiter #(.N(N)) u_arb (
    .req        (slotFull),
    .ptr        (ptr),
    .lock       (lock),
    .grant      (grant),
    .grantValid (grant_valid)
  );

  // Output mux from the registered slots; idle outputs are driven to zero.
  always_comb begin
    outValid   = grant_valid;
    outChannel = '0;
    outData    = '0;
    if (grant_valid) begin
      outChannel = grant;
      outData    = slot_data[grant];
    end
    fire      = grant_valid & outReady;
    multi_now = (inStrobe & (inStrobe - N'(1))) != '0;
  end

  // Slot capture and drain, sticky flags, and the round-robin pointer and lock.
  // While stalled, the pointer is parked on the granted slot. A locked search from
  // there yields the same slot, and the granted slot cannot change because a full
  // slot ignores new captures.
  always_ff @(posedge clk) begin
    if (reset) begin
      slotFull <= '0;
      overflow <= '0;
      multiHot <= 1'b0;
      ptr      <= '0;
      lock     <= 1'b0;
      for (int unsigned i = 0; i < N; i++) slot_data[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (inStrobe[i]) begin
          if (!slotFull[i] || (fire && grant == LOGN'(i))) begin
            slot_data[i] <= inData;
            slotFull[i]  <= 1'b1;
            if (clearFlags) overflow[i] <= 1'b0;
          end else begin
            overflow[i] <= 1'b1;
          end
        end else begin
          if (fire && grant == LOGN'(i)) slotFull[i] <= 1'b0;
          if (clearFlags) overflow[i] <= 1'b0;
        end
      end
      if (multi_now) multiHot <= 1'b1;
      else if (clearFlags) multiHot <= 1'b0;
      if (fire) begin
        ptr  <= (grant == LOGN'(N - 1)) ? '0 : grant + LOGN'(1);
        lock <= 1'b0;
      end else if (grant_valid) begin
        ptr  <= grant;
        lock <= 1'b1;
      end else begin
        lock <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_demux_capture_bank.sv
// Bench for demux_capture_bank. A behavioural model tracks slot contents, flags, the
// pointer and the held presentation. Every cycle a compare process checks all DUT
// outputs against the model. Directed pins check hand-computed values.
module tb_demux_capture_bank;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] strobe = '0;
  logic [W-1:0] din = '0;
  logic         rdy = 1'b0;
  logic         clr = 1'b0;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_channel;
  logic [N-1:0] slot_full;
  logic [N-1:0] ovf;
  logic         multi_hot;

  int tests = 0;
  int fails = 0;

  // Model state.
  bit           armed = 0;
  bit           m_full [N];
  logic [W-1:0] m_data [N];
  bit           m_ovf  [N];
  bit           m_mh;
  int           m_ptr;
  bit           m_held;
  int           m_held_ch;

  demux_capture_bank #(.N(N), .W(W)) dut (
    .clk        (clk),
    .reset      (rst),
    .inStrobe   (strobe),
    .inData     (din),
    .outValid   (out_valid),
    .outReady   (rdy),
    .outData    (out_data),
    .outChannel (out_channel),
    .slotFull   (slot_full),
    .overflow   (ovf),
    .multiHot   (multi_hot),
    .clearFlags (clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Channel the consumer must see now, or -1 when nothing is pending.
  function automatic int pick();
    if (m_held) return m_held_ch;
    for (int k = 0; k < N; k++)
      if (m_full[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] vec(input bit a [N]);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = a[i];
    return v;
  endfunction

  task automatic model_step();
    int p;
    bit fire;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_full[i] = 0; m_data[i] = '0; m_ovf[i] = 0;
      end
      m_mh = 0; m_ptr = 0; m_held = 0; m_held_ch = 0;
      armed = 1;
      return;
    end
    p = pick();
    fire = (p >= 0) && rdy;
    if (clr) begin
      for (int i = 0; i < N; i++) m_ovf[i] = 0;
      m_mh = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (strobe[i]) begin
        if (!m_full[i] || (fire && p == i)) begin
          m_data[i] = din;
          m_full[i] = 1;
        end else begin
          m_ovf[i] = 1;
        end
      end else if (fire && p == i) begin
        m_full[i] = 0;
      end
    end
    if ($countones(strobe) > 1) m_mh = 1;
    if (fire) begin
      m_ptr = (p + 1) % N;
      m_held = 0;
    end else if (p >= 0) begin
      m_held = 1;
      m_held_ch = p;
    end
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then settle.
  task automatic drive(input logic [N-1:0] s, input logic [W-1:0] d,
                       input logic r, input logic c, input logic rs);
    strobe = s; din = d; rdy = r; clr = c; rst = rs;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (armed) begin
      int p;
      p = pick();
      chk("outValid", 32'(out_valid), 32'(p >= 0));
      chk("outChannel", 32'(out_channel), (p >= 0) ? 32'(p) : 32'd0);
      chk("outData", 32'(out_data), (p >= 0) ? 32'(m_data[p]) : 32'd0);
      chk("slotFull", 32'(slot_full), 32'(vec(m_full)));
      chk("overflow", 32'(ovf), 32'(vec(m_ovf)));
      chk("multiHot", 32'(multi_hot), 32'(m_mh));
    end
  end

  initial begin
    // 1: reset, idle, single capture.
    drive('0, '0, 0, 0, 1);
    drive('0, '0, 0, 0, 1);
    chk("t1_rst_valid", 32'(out_valid), 0);
    chk("t1_rst_full", 32'(slot_full), 0);
    chk("t1_rst_ovf", 32'(ovf), 0);
    chk("t1_rst_mh", 32'(multi_hot), 0);
    drive(4'b0010, 8'hA5, 1, 0, 0);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_ch", 32'(out_channel), 1);
    chk("t1_data", 32'(out_data), 32'hA5);
    drive('0, '0, 1, 0, 0);
    chk("t1_drained", 32'(slot_full), 0);

    // 2: round-robin order.
    drive(4'b0001, 8'h10, 0, 0, 0);
    drive(4'b0010, 8'h11, 0, 0, 0);
    drive(4'b0100, 8'h12, 0, 0, 0);
    drive(4'b1000, 8'h13, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      chk("t2_ch", 32'(out_channel), 32'(k));
      chk("t2_data", 32'(out_data), 32'h10 + 32'(k));
      drive('0, '0, 1, 0, 0);
    end
    chk("t2_empty", 32'(out_valid), 0);
    drive(4'b1001, 8'h20, 0, 0, 0);
    chk("t2_ch0", 32'(out_channel), 0);
    drive('0, '0, 1, 0, 0);
    chk("t2_ch3", 32'(out_channel), 3);
    drive('0, '0, 1, 0, 0);
    chk("t2_empty2", 32'(out_valid), 0);

    // 3: back-pressure holds the presented slot.
    drive(4'b0100, 8'h5C, 0, 0, 0);
    drive(4'b0001, 8'h01, 0, 0, 0);
    drive(4'b1000, 8'h03, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      chk("t3_hold_ch", 32'(out_channel), 2);
      chk("t3_hold_data", 32'(out_data), 32'h5C);
      drive('0, '0, 0, 0, 0);
    end
    chk("t3_hold_ch", 32'(out_channel), 2);
    drive('0, '0, 1, 0, 0);
    chk("t3_next_ch", 32'(out_channel), 3);
    chk("t3_next_data", 32'(out_data), 32'h03);
    drive('0, '0, 1, 0, 0);
    drive('0, '0, 1, 0, 0);
    chk("t3_empty", 32'(out_valid), 0);

    // 4: overflow on a full, non-granted slot, then clear.
    drive(4'b0100, 8'h42, 0, 0, 0);
    drive(4'b0010, 8'h41, 0, 0, 0);
    drive(4'b0010, 8'hFF, 0, 0, 0);
    chk("t4_ovf", 32'(ovf), 32'b0010);
    drive('0, '0, 0, 1, 0);
    chk("t4_clr", 32'(ovf), 0);
    drive('0, '0, 1, 0, 0);
    chk("t4_ch", 32'(out_channel), 1);
    chk("t4_kept", 32'(out_data), 32'h41);
    drive('0, '0, 1, 0, 0);

    // 5: drain and recapture of the same slot in one cycle.
    drive(4'b0001, 8'h50, 0, 0, 0);
    drive(4'b0001, 8'h77, 1, 0, 0);
    chk("t5_full", 32'(slot_full), 32'b0001);
    chk("t5_ovf", 32'(ovf), 0);
    chk("t5_data", 32'(out_data), 32'h77);
    drive('0, '0, 1, 0, 0);

    // 6: multi-hot capture, then reset while valid.
    drive(4'b0101, 8'h3C, 0, 0, 0);
    chk("t6_mh", 32'(multi_hot), 1);
    chk("t6_full", 32'(slot_full), 32'b0101);
    chk("t6_data", 32'(out_data), 32'h3C);
    drive(4'b0010, 8'h99, 1, 0, 1);
    chk("t6_rst_valid", 32'(out_valid), 0);
    chk("t6_rst_full", 32'(slot_full), 0);
    chk("t6_rst_mh", 32'(multi_hot), 0);
    chk("t6_rst_ch", 32'(out_channel), 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [N-1:0] s;
      s = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      drive(s, W'($urandom), ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 199) == 0));
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
